// File: rtl/seq_alu_if.sv
// Operand/result bundle between the control unit (master) and the sequential ALU (slave).
// Start/ALUCtrl/BusA/BusB flow into the ALU; the registered result and flags flow back.
interface seq_alu_if #(
   parameter int WIDTH = 64
);
   logic             Start;
   logic [3:0]       ALUCtrl;
   logic [WIDTH-1:0] BusA;
   logic [WIDTH-1:0] BusB;
   logic [WIDTH-1:0] BusW;
   logic             Zero;
   logic             Negative;
   logic             Carry;
   logic             Overflow;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, ALUCtrl, BusA, BusB,
      input  BusW, Zero, Negative, Carry, Overflow, Busy, Done
   );

   modport slave (
      input  Start, ALUCtrl, BusA, BusB,
      output BusW, Zero, Negative, Carry, Overflow, Busy, Done
   );
endinterface

// File: rtl/seq_alu.sv
// Registered, handshaked ALU: single-cycle logic/arith/shift ops and an
// iterative shift-add multiply that takes WIDTH cycles from Start to Done.
module seq_alu #(
   parameter int WIDTH = 64
) (
   input logic       Clk,
   input logic       Reset,
   seq_alu_if.slave  bus
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_LSL = 4'b0011;
   localparam logic [3:0] OP_LSR = 4'b0100;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_PSB = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   localparam logic [SHW:0] LAST_ITER = (SHW + 1)'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE,
      MUL
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] busw_q, busw_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [SHW-1:0]   shamt;

   logic             commit;
   logic [WIDTH-1:0] commit_res;
   logic             commit_c;
   logic             commit_v;
   logic [WIDTH-1:0] acc_step;

   // Single-cycle datapath; subtraction is A + ~B + 1 so Carry means "no borrow".
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      shamt   = bus.BusB[SHW-1:0];
      sum_add = {1'b0, bus.BusA} + {1'b0, bus.BusB};
      sum_sub = {1'b0, bus.BusA} + {1'b0, ~bus.BusB} + (WIDTH + 1)'(1);
      case (bus.ALUCtrl)
         OP_AND: alu_res = bus.BusA & bus.BusB;
         OP_OR:  alu_res = bus.BusA | bus.BusB;
         OP_ADD: begin
            alu_res = sum_add[WIDTH-1:0];
            alu_c   = sum_add[WIDTH];
            alu_v   = (bus.BusA[WIDTH-1] == bus.BusB[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.BusA[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sum_sub[WIDTH-1:0];
            alu_c   = sum_sub[WIDTH];
            alu_v   = (bus.BusA[WIDTH-1] != bus.BusB[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != bus.BusA[WIDTH-1]);
         end
         OP_PSB: alu_res = bus.BusB;
         OP_LSL: alu_res = bus.BusA << shamt;
         OP_LSR: alu_res = bus.BusA >> shamt;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      busw_d     = busw_q;
      zero_d     = zero_q;
      neg_d      = neg_q;
      carry_d    = carry_q;
      ovf_d      = ovf_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      commit     = 1'b0;
      commit_res = '0;
      commit_c   = 1'b0;
      commit_v   = 1'b0;
      acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               if (bus.ALUCtrl == OP_MUL) begin
                  state_d  = MUL;
                  busy_d   = 1'b1;
                  mcand_d  = bus.BusA;
                  mplier_d = bus.BusB;
                  op_d     = bus.ALUCtrl;
                  acc_d    = '0;
                  cnt_d    = '0;
               end else begin
                  commit     = 1'b1;
                  commit_res = alu_res;
                  commit_c   = alu_c;
                  commit_v   = alu_v;
               end
            end
         end
         MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d    = IDLE;
               busy_d     = 1'b0;
               commit     = 1'b1;
               commit_res = (op_q == OP_MUL) ? acc_step : '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Zero and Negative always follow whatever value lands in BusW.
      if (commit) begin
         busw_d  = commit_res;
         zero_d  = (commit_res == '0);
         neg_d   = commit_res[WIDTH-1];
         carry_d = commit_c;
         ovf_d   = commit_v;
         done_d  = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         busw_q   <= '0;
         zero_q   <= 1'b1;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
      end else begin
         state_q  <= state_d;
         busw_q   <= busw_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
      end
   end

   assign bus.BusW     = busw_q;
   assign bus.Zero     = zero_q;
   assign bus.Negative = neg_q;
   assign bus.Carry    = carry_q;
   assign bus.Overflow = ovf_q;
   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner cases followed by randomized ops,
// each compared against an arithmetic reference model of the ALU.
module tb_seq_alu;

   localparam int W = 64;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_LSL = 4'b0011;
   localparam logic [3:0] OP_LSR = 4'b0100;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_PSB = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         n;
      logic         c;
      logic         v;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   int   n_vectors = 0;
   int   n_miscompares = 0;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // Reference: signed overflow is "the true signed result does not fit in W bits".
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t                e;
      logic [W:0]          wide;
      logic signed [W+1:0] s;
      int                  sh;
      e    = '0;
      sh   = int'(b % W);
      wide = '0;
      s    = '0;
      case (op)
         OP_AND: e.res = a & b;
         OP_OR:  e.res = a | b;
         OP_ADD: begin
            wide  = {1'b0, a} + {1'b0, b};
            e.res = wide[W-1:0];
            e.c   = wide[W];
            s     = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
            e.v   = (s != $signed({{2{e.res[W-1]}}, e.res}));
         end
         OP_SUB: begin
            e.res = a - b;
            e.c   = (a >= b);
            s     = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
            e.v   = (s != $signed({{2{e.res[W-1]}}, e.res}));
         end
         OP_PSB: e.res = b;
         OP_LSL: e.res = a << sh;
         OP_LSR: e.res = a >> sh;
         OP_MUL: e.res = a * b;
         default: e.res = '0;
      endcase
      e.z = (e.res == '0);
      e.n = e.res[W-1];
      return e;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] corner [5];
      corner[0] = '0;
      corner[1] = W'(1);
      corner[2] = ONES;
      corner[3] = SMAX;
      corner[4] = SMIN;
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
      return {$urandom, $urandom};
   endfunction

   task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vectors++;
      assert (obs === exp) else begin
         n_miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input exp_t e);
      check_output({tag, " Done"},     W'(bus.Done),     W'(1));
      check_output({tag, " BusW"},     bus.BusW,         e.res);
      check_output({tag, " Zero"},     W'(bus.Zero),     W'(e.z));
      check_output({tag, " Negative"}, W'(bus.Negative), W'(e.n));
      check_output({tag, " Carry"},    W'(bus.Carry),    W'(e.c));
      check_output({tag, " Overflow"}, W'(bus.Overflow), W'(e.v));
   endtask

   task automatic check_reset_state(input string tag);
      exp_t e;
      e = '0;
      e.z = 1'b1;
      check_output({tag, " Done"},     W'(bus.Done),     '0);
      check_output({tag, " Busy"},     W'(bus.Busy),     '0);
      check_output({tag, " BusW"},     bus.BusW,         e.res);
      check_output({tag, " Zero"},     W'(bus.Zero),     W'(e.z));
      check_output({tag, " Negative"}, W'(bus.Negative), W'(e.n));
      check_output({tag, " Carry"},    W'(bus.Carry),    W'(e.c));
      check_output({tag, " Overflow"}, W'(bus.Overflow), W'(e.v));
   endtask

   task automatic apply_stimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.Start   = 1'b1;
      bus.ALUCtrl = op;
      bus.BusA    = a;
      bus.BusB    = b;
   endtask

   // Operands are don't-care between accepts, so scramble them.
   task automatic idle_inputs();
      bus.Start   = 1'b0;
      bus.ALUCtrl = 4'($urandom);
      bus.BusA    = {$urandom, $urandom};
      bus.BusB    = {$urandom, $urandom};
   endtask

   task automatic single_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e = model(op, a, b);
      @(negedge Clk);
      apply_stimulus(op, a, b);
      @(negedge Clk);
      idle_inputs();
      check_output({tag, " Busy"}, W'(bus.Busy), '0);
      check_result(tag, e);
      @(negedge Clk);
      check_output({tag, " Done pulse"}, W'(bus.Done), '0);
      check_output({tag, " hold"}, bus.BusW, e.res);
   endtask

   task automatic mul_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int ignore_at);
      exp_t e;
      int   cycles;
      int   busy_cnt;
      e        = model(OP_MUL, a, b);
      cycles   = 0;
      busy_cnt = 0;
      @(negedge Clk);
      apply_stimulus(OP_MUL, a, b);
      @(negedge Clk);
      idle_inputs();
      while (bus.Done !== 1'b1 && cycles < 4 * W) begin
         if (bus.Busy === 1'b1) busy_cnt++;
         if (cycles == ignore_at) apply_stimulus(OP_ADD, rand_word(), rand_word());
         else idle_inputs();
         @(negedge Clk);
         cycles++;
      end
      idle_inputs();
      check_output({tag, " Busy cycles"}, W'(busy_cnt), W'(W));
      check_output({tag, " Busy at Done"}, W'(bus.Busy), '0);
      check_result(tag, e);
      @(negedge Clk);
      check_output({tag, " Done pulse"}, W'(bus.Done), '0);
      check_output({tag, " hold"}, bus.BusW, e.res);
   endtask

   initial begin
      logic [3:0] op_pool [10];
      exp_t       e1;
      exp_t       e2;
      logic       done_seen;

      op_pool[0] = OP_AND; op_pool[1] = OP_OR;  op_pool[2] = OP_ADD; op_pool[3] = OP_SUB;
      op_pool[4] = OP_PSB; op_pool[5] = OP_LSL; op_pool[6] = OP_LSR; op_pool[7] = 4'b0101;
      op_pool[8] = 4'b1001; op_pool[9] = 4'b1111;

      Reset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      check_reset_state("reset");

      single_op("add wrap", OP_ADD, ONES, W'(1));
      single_op("add ovf", OP_ADD, SMAX, W'(1));
      single_op("sub 5-7", OP_SUB, W'(5), W'(7));
      single_op("sub equal", OP_SUB, W'(9), W'(9));
      single_op("sub min-1", OP_SUB, SMIN, W'(1));

      // Back-to-back: second Start lands in the cycle the first Done is high.
      e1 = model(OP_LSL, W'(1), W'(63));
      e2 = model(OP_LSR, W'(64'hF0), W'(64'h40));
      @(negedge Clk);
      apply_stimulus(OP_LSL, W'(1), W'(63));
      @(negedge Clk);
      check_result("b2b lsl", e1);
      apply_stimulus(OP_LSR, W'(64'hF0), W'(64'h40));
      @(negedge Clk);
      idle_inputs();
      check_result("b2b lsr", e2);
      @(negedge Clk);
      check_output("b2b Done pulse", W'(bus.Done), '0);

      mul_op("mul 3x5", W'(3), W'(5), 20);
      @(negedge Clk);
      check_output("mul ignored start no Done", W'(bus.Done), '0);
      check_output("mul ignored start BusW", bus.BusW, W'(15));
      mul_op("mul ones x2", ONES, W'(2), -1);

      // Reset in the middle of a multiply discards it entirely.
      @(negedge Clk);
      apply_stimulus(OP_MUL, ONES, W'(2));
      @(negedge Clk);
      idle_inputs();
      repeat (9) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check_reset_state("abort");
      done_seen = 1'b0;
      repeat (W + 4) begin
         @(negedge Clk);
         if (bus.Done === 1'b1) done_seen = 1'b1;
      end
      check_output("abort no Done", W'(done_seen), '0);
      mul_op("mul after abort", ONES, W'(2), -1);

      single_op("illegal 1111", 4'b1111, W'(64'h1234), W'(64'h1234));

      for (int i = 0; i < 40; i++) begin
         single_op($sformatf("rand op %0d", i), op_pool[$urandom_range(0, 9)], rand_word(), rand_word());
      end
      for (int i = 0; i < 5; i++) begin
         mul_op($sformatf("rand mul %0d", i), rand_word(), rand_word(), int'($urandom_range(0, W - 2)));
      end

      $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
